mips_fetch_unit: RTL and testbench
==================================

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning PC and memory address width.
REQ-002 The block SHALL have parameter MEM_W, default 8, meaning memory data beat width.
REQ-003 The block SHALL have parameter INSTR_W, default 32, meaning assembled instruction width; INSTR_W SHALL be an integer multiple of MEM_W, with BEATS = INSTR_W/MEM_W and BEATS >= 1.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port mem_req  output  1  meaning fetch beat request.
REQ-007 The block SHALL have port mem_addr  output  ADDR_W  meaning byte address of the current beat.
REQ-008 The block SHALL have port mem_ready  input  1  meaning memdata valid and beat accepted this cycle.
REQ-009 The block SHALL have port memdata  input  MEM_W  meaning memory read data.
REQ-010 The block SHALL have port instr  output  INSTR_W  meaning assembled instruction register.
REQ-011 The block SHALL have port op  output  6  meaning instr[INSTR_W-1:INSTR_W-6].
REQ-012 The block SHALL have port funct  output  6  meaning instr[5:0].
REQ-013 The block SHALL have port instr_valid  output  1  meaning instr holds a complete instruction.
REQ-014 The block SHALL have port instr_ready  input  1  meaning consumer accepts instr.
REQ-015 The block SHALL have port redirect  input  1  meaning branch/jump redirect request.
REQ-016 The block SHALL have port redirect_pc  input  ADDR_W  meaning redirect target.
REQ-017 The block SHALL have port pc  output  ADDR_W  meaning address of the instruction being fetched or held.
REQ-018 The block SHALL have port fetch_count  output  16  meaning saturating count of delivered instructions.

Function
REQ-019 The block SHALL implement two states: FETCH and HOLD; internal beat counter beat in 0..BEATS-1.
REQ-020 mem_req SHALL equal 1 exactly in FETCH with redirect low; mem_addr SHALL equal (pc + beat) mod 2^ADDR_W, combinationally.
REQ-021 On a cycle with mem_req and mem_ready high, memdata SHALL be written to instr[beat*MEM_W +: MEM_W] (beat 0 = least significant lane), other lanes unchanged.
REQ-022 Accepted beat with beat < BEATS-1: beat increments, state stays FETCH.
REQ-023 Accepted beat with beat = BEATS-1: beat <= 0, state <= HOLD, instr_valid <= 1 (registered, visible the following cycle).
REQ-024 FETCH with mem_ready low: no state, beat or instr change (wait states unlimited).
REQ-025 HOLD with instr_ready high: instr_valid <= 0, pc <= (pc + BEATS) mod 2^ADDR_W, fetch_count increments (saturating at 16'hFFFF), state <= FETCH; instr retains its value.
REQ-026 HOLD with instr_ready low: all outputs held stable.
REQ-027 Minimum latency: BEATS cycles of fetch plus one HOLD cycle per instruction with zero wait states; one-cycle bubble after each handshake.
REQ-028 redirect SHALL have highest priority in any state: pc <= redirect_pc, beat <= 0, instr_valid <= 0, state <= FETCH; partial instruction discarded, instr lanes not written that cycle, fetch_count unchanged.
REQ-029 redirect and instr_ready both high in HOLD: redirect wins; the held instruction is dropped, not counted.
REQ-030 redirect_pc need not be BEATS-aligned; fetch proceeds from the given address.
REQ-031 Address wrap: pc and mem_addr arithmetic SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-032 instr_ready outside HOLD SHALL be ignored.

Reset
REQ-033 While reset is high at a clock edge: pc=0, beat=0, state=FETCH, instr=0, instr_valid=0, fetch_count=0; reset SHALL override redirect and mem_ready.
REQ-034 Reset asserted mid-fetch SHALL discard partial data; first beat after release requests address 0.

Verification
REQ-035 Defaults, zero wait: memdata 20,00,22,00 at addr 0..3 -> instr=32'h00220020 after 4 beats, op=0, funct=6'h20, instr_valid next cycle; instr_ready -> pc=4, fetch_count=1.
REQ-036 mem_ready held low 3 cycles on beat 2 -> mem_addr stays 2, no lane written; final instr identical to REQ-035.
REQ-037 redirect with redirect_pc=8'h40 after 2 beats -> next mem_addr=8'h40, beat 0, instr_valid=0, fetch_count unchanged.
REQ-038 redirect_pc=8'hFE, 4 beats -> mem_addr sequence FE,FF,00,01; after handshake pc=8'h02.
REQ-039 redirect and instr_ready together in HOLD -> instr_valid=0, fetch_count unchanged, pc=redirect_pc.
REQ-040 Reset pulsed during beat 1 -> instr=0, instr_valid=0, mem_addr=0 next cycle after release; repeat with MEM_W=16, INSTR_W=32 (BEATS=2) for REQ-035 equivalent.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
//   Multi-beat instruction fetch unit. An instruction of INSTR_W bits is
//   assembled from BEATS = INSTR_W/MEM_W memory beats, fetched least
//   significant lane first from consecutive byte addresses starting at pc.
//   Once complete, the instruction is held until the consumer accepts it;
//   pc then advances by BEATS and the delivered-instruction count steps.
//   A redirect restarts fetch from redirect_pc in any state.
//
// Handshakes:
//   memory side:   a beat transfers on a cycle where mem_req && mem_ready.
//   consumer side: an instruction transfers on a cycle where
//                  instr_valid && instr_ready && !redirect.
//   instr_valid never drops without a transfer except on redirect/reset.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_req, mem_addr     beat request and its byte address (pc + beat)
//   mem_ready, memdata    beat accepted / read data
//   instr, op, funct      assembled instruction and its op/funct fields
//   instr_valid           instr holds a complete instruction
//   instr_ready           consumer accepts instr (only used in HOLD)
//   redirect, redirect_pc branch/jump restart request and target
//   pc                    address of the instruction being fetched or held
//   fetch_count           saturating count of delivered instructions
//   dbg_state             current FSM state (0 = FETCH, 1 = HOLD)
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int MEM_W   = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [MEM_W-1:0]   memdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        fetch_count,
  output logic               dbg_state
);

  localparam int BEATS  = INSTR_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               r_state;
  logic [BEAT_W-1:0]    r_beat;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_valid;
  logic [15:0]          r_count;

  state_t               w_state_nxt;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic                 w_valid_nxt;
  logic [15:0]          w_count_nxt;
  logic                 w_lane_we;

  // Next-state and output decode. Redirect outranks everything, including a
  // beat that memory is presenting in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_lane_we   = 1'b0;
    mem_req     = (r_state == ST_FETCH) && !redirect;

    if (redirect) begin
      w_state_nxt = ST_FETCH;
      w_beat_nxt  = '0;
      w_pc_nxt    = redirect_pc;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            w_lane_we = 1'b1;
            if (r_beat == LAST_BEAT) begin
              w_beat_nxt  = '0;
              w_state_nxt = ST_HOLD;
              w_valid_nxt = 1'b1;
            end else begin
              w_beat_nxt = r_beat + BEAT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            w_state_nxt = ST_FETCH;
            w_valid_nxt = 1'b0;
            w_pc_nxt    = r_pc + ADDR_W'(BEATS);
            w_count_nxt = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
          end
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat  <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_beat  <= w_beat_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      if (w_lane_we) begin
        r_instr[int'(r_beat) * MEM_W +: MEM_W] <= memdata;
      end
    end
  end

  assign mem_addr    = r_pc + ADDR_W'(r_beat);
  assign instr       = r_instr;
  assign op          = r_instr[INSTR_W-1 -: 6];
  assign funct       = r_instr[5:0];
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign fetch_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: defaults (8-bit beats, 4 beats per instruction)
  logic        reset = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ready = 1'b0;
  logic [7:0]  memdata;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  pc;
  logic [15:0] fetch_count;
  logic        dbg_state;

  logic [7:0]  mem [256];
  assign memdata = mem[mem_addr];

  mips_fetch_unit u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .memdata(memdata), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  // second DUT: 16-bit beats, 2 beats per instruction
  logic        reset16 = 1'b1;
  logic        mem_req16;
  logic [7:0]  mem_addr16;
  logic        mem_ready16 = 1'b0;
  logic [15:0] memdata16;
  logic [31:0] instr16;
  logic [5:0]  op16, funct16;
  logic        valid16;
  logic        instr_ready16 = 1'b0;
  logic        redirect16 = 1'b0;
  logic [7:0]  redirect_pc16 = 8'h00;
  logic [7:0]  pc16;
  logic [15:0] count16;
  logic        dbg_state16;

  assign memdata16 = (mem_addr16 == 8'd0) ? 16'h0020 :
                     (mem_addr16 == 8'd1) ? 16'h0022 : 16'hBEEF;

  mips_fetch_unit #(.ADDR_W(8), .MEM_W(16), .INSTR_W(32)) u_dut16 (
    .clk(clk), .reset(reset16), .mem_req(mem_req16), .mem_addr(mem_addr16),
    .mem_ready(mem_ready16), .memdata(memdata16), .instr(instr16), .op(op16),
    .funct(funct16), .instr_valid(valid16), .instr_ready(instr_ready16),
    .redirect(redirect16), .redirect_pc(redirect_pc16), .pc(pc16),
    .fetch_count(count16), .dbg_state(dbg_state16)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  // entry = {pc[7:0], fetch_count[15:0], instr[31:0]}
  logic [55:0] exp_q[$];
  logic [7:0]  model_pc    = 8'h00;
  logic [15:0] model_count = 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an instruction is the little-endian concatenation of the
  // BEATS bytes starting at its pc, addresses wrapping at 256.
  function automatic logic [31:0] model_instr(input logic [7:0] p);
    logic [31:0] r;
    logic [7:0]  a;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = p + 8'(i);
      r[i*8 +: 8] = mem[a];
    end
    return r;
  endfunction

  task automatic push_exp();
    exp_q.push_back({model_pc, model_count, model_instr(model_pc)});
  endtask

  // monitor: every consumer-side transfer is compared against the queue head
  always @(negedge clk) begin
    logic [55:0] e;
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none at %0t", instr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", 64'(instr), 64'(e[31:0]));
        chk("sb_pc",    64'(pc), 64'(e[55:48]));
        chk("sb_count", 64'(fetch_count), 64'(e[47:32]));
        chk("sb_op",    64'(op), 64'(e[31:26]));
        chk("sb_funct", 64'(funct), 64'(e[5:0]));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Drive one cycle of inputs just after the rising edge and advance the
  // model with what the coming edge will do.
  task automatic cyc(input logic rst, input logic rd, input logic [7:0] rpc,
                     input logic ir, input logic mr);
    @(posedge clk);
    #1;
    reset = rst; redirect = rd; redirect_pc = rpc; instr_ready = ir; mem_ready = mr;
    if (rst) begin
      exp_q.delete();
      model_pc = 8'h00;
      model_count = 16'h0000;
      push_exp();
    end else if (rd) begin
      exp_q.delete();
      model_pc = rpc;
      push_exp();
    end else if (instr_valid && ir) begin
      model_pc = model_pc + 8'd4;
      if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
      push_exp();
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // random ready/wait traffic until `target` instructions have been delivered
  task automatic run_until(input logic [15:0] target, input int max_cycles);
    for (int i = 0; i < max_cycles && model_count != target; i++)
      cyc(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    idle();
    @(negedge clk);
    chk("deliver_count", 64'(fetch_count), 64'(target));
  endtask

  task automatic cyc16(input logic rst, input logic mr, input logic ir);
    @(posedge clk);
    #1;
    reset16 = rst; mem_ready16 = mr; instr_ready16 = ir;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'h22; mem[3] = 8'h00;

    // reset state
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);

    // zero-wait fetch of 32'h00220020 from address 0
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      chk("zw_mem_addr", 64'(mem_addr), 64'(k));
      chk("zw_mem_req", 64'(mem_req), 64'h1);
    end
    idle();
    @(negedge clk);
    chk("zw_valid", 64'(instr_valid), 64'h1);
    chk("zw_instr", 64'(instr), 64'h00220020);
    chk("zw_op", 64'(op), 64'h0);
    chk("zw_funct", 64'(funct), 64'h20);
    chk("zw_hold_no_req", 64'(mem_req), 64'h0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("zw_pc_after", 64'(pc), 64'h4);
    chk("zw_count_after", 64'(fetch_count), 64'h1);
    chk("zw_valid_after", 64'(instr_valid), 64'h0);

    // wait states on beat 2
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("ws_mem_addr", 64'(mem_addr), 64'h2);
      chk("ws_valid", 64'(instr_valid), 64'h0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("ws_instr", 64'(instr), 64'h00220020);
    chk("ws_valid_done", 64'(instr_valid), 64'h1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("ws_count", 64'(fetch_count), 64'h2);

    // redirect after two beats
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
    @(negedge clk);
    chk("rd_no_req", 64'(mem_req), 64'h0);
    idle();
    @(negedge clk);
    chk("rd_mem_addr", 64'(mem_addr), 64'h40);
    chk("rd_pc", 64'(pc), 64'h40);
    chk("rd_valid", 64'(instr_valid), 64'h0);
    chk("rd_count", 64'(fetch_count), 64'h2);
    run_until(16'd3, 200);

    // unaligned target with address wrap
    cyc(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      chk("wrap_mem_addr", 64'(mem_addr), 64'(8'(8'hFE + 8'(k))));
    end
    idle();
    @(negedge clk);
    chk("wrap_instr", 64'(instr), 64'(model_instr(8'hFE)));
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("wrap_pc", 64'(pc), 64'h02);

    // redirect and instr_ready together in HOLD
    for (int i = 0; i < 20 && !instr_valid; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("rr_in_hold", 64'(instr_valid), 64'h1);
    cyc(1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("rr_valid", 64'(instr_valid), 64'h0);
    chk("rr_count", 64'(fetch_count), 64'h4);
    chk("rr_pc", 64'(pc), 64'h80);

    // reset pulsed during beat 1
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("rb_instr", 64'(instr), 64'h0);
    chk("rb_valid", 64'(instr_valid), 64'h0);
    chk("rb_mem_addr", 64'(mem_addr), 64'h0);
    chk("rb_count", 64'(fetch_count), 64'h0);
    run_until(16'd1, 200);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0));
    repeat (3) idle();

    // 16-bit beat configuration
    cyc16(1'b1, 1'b0, 1'b0);
    cyc16(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("w16_rst_instr", 64'(instr16), 64'h0);
    chk("w16_rst_valid", 64'(valid16), 64'h0);
    cyc16(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("w16_addr0", 64'(mem_addr16), 64'h0);
    cyc16(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("w16_addr1", 64'(mem_addr16), 64'h1);
    cyc16(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("w16_valid", 64'(valid16), 64'h1);
    chk("w16_instr", 64'(instr16), 64'h00220020);
    chk("w16_funct", 64'(funct16), 64'h20);
    chk("w16_op", 64'(op16), 64'h0);
    cyc16(1'b0, 1'b0, 1'b1);
    cyc16(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("w16_pc", 64'(pc16), 64'h2);
    chk("w16_count", 64'(count16), 64'h1);
    chk("w16_valid_after", 64'(valid16), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL tb_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
